// File: rtl/hamming_tx_encoder.sv
// hamming_tx_encoder
// Captures a WIDTH-bit word, computes a Hamming(7,4) parity triple for every
// 4-bit block at load time, then streams the 7-bit codewords out over a
// valid/ready link, LANES codewords per beat, lowest block in lane 0.
// Parity matches the counter parity store: p2=d0^d2^d3, p1=d0^d1^d3,
// p0=d0^d1^d2, codeword = {p2,p1,p0,d3,d2,d1,d0}.
//
// Optional build macro HAM_TX_ERR_INJECT_EN adds inj_arm/inj_block/inj_bit,
// which flip one codeword bit of one block for a single frame.
//
// state | meaning
// IDLE  | waiting for a word; load_ready high, tx_valid low
// SEND  | presenting beats of the captured frame until the last is accepted
module hamming_tx_encoder #(
  parameter  int WIDTH  = 128,
  parameter  int LANES  = 4,
  localparam int BLOCKS = WIDTH / 4,
  localparam int BEATS  = BLOCKS / LANES,
  localparam int IDXW   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [WIDTH-1:0]   load_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [LANES*7-1:0] tx_data,
  output logic [IDXW-1:0]    tx_idx,
  output logic               tx_last,
  output logic               busy,
  output logic               frame_done
`ifdef HAM_TX_ERR_INJECT_EN
  ,
  input  logic                                          inj_arm,
  input  logic [((BLOCKS > 1) ? $clog2(BLOCKS) : 1)-1:0] inj_block,
  input  logic [2:0]                                    inj_bit
`endif
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    rdy_q, rdy_d;
  logic                    done_q, done_d;
  logic                    capture;
  logic [WIDTH-1:0]        word_q;
  logic [BLOCKS-1:0][2:0]  par_q;
  logic [BLOCKS-1:0][2:0]  par_in;
  logic [BLOCKS*7-1:0]     cw_all;

  function automatic logic [2:0] ham_parity(input logic [3:0] d);
    return {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
  endfunction

  // Parity of the incoming word, registered alongside it on the load edge.
  always_comb begin
    for (int b = 0; b < BLOCKS; b++) begin
      par_in[b] = ham_parity(load_data[b*4 +: 4]);
    end
  end

  // State, beat index, registered ready and frame-done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic, beat advance and handshake outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    capture  = 1'b0;
    tx_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid && rdy_q) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          if (idx_q == IDXW'(BEATS - 1)) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
    // Ready is registered so it stays low through reset and for the
    // first edge after release.
    rdy_d = (state_d == IDLE);
  end

  // Held word and parity; only a new load changes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      par_q  <= '0;
    end else if (capture) begin
      word_q <= load_data;
      par_q  <= par_in;
    end
  end

`ifdef HAM_TX_ERR_INJECT_EN
  localparam int BLKW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

  logic            inj_arm_q;
  logic [BLKW-1:0] inj_block_q;
  logic [2:0]      inj_bit_q;

  // Injection request sampled with the word; bit index 7 disarms it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_arm_q   <= 1'b0;
      inj_block_q <= '0;
      inj_bit_q   <= '0;
    end else if (capture) begin
      inj_arm_q   <= inj_arm && (inj_bit != 3'd7);
      inj_block_q <= inj_block;
      inj_bit_q   <= inj_bit;
    end
  end

  // Codewords for the whole frame, with the optional single-bit flip.
  always_comb begin
    for (int b = 0; b < BLOCKS; b++) begin
      cw_all[b*7 +: 7] = {par_q[b], word_q[b*4 +: 4]};
      if (inj_arm_q && (inj_block_q == BLKW'(b))) begin
        cw_all[b*7 +: 7] = cw_all[b*7 +: 7] ^ (7'd1 << inj_bit_q);
      end
    end
  end
`else
  // Codewords for the whole frame.
  always_comb begin
    for (int b = 0; b < BLOCKS; b++) begin
      cw_all[b*7 +: 7] = {par_q[b], word_q[b*4 +: 4]};
    end
  end
`endif

  assign tx_data    = tx_valid ? cw_all[int'(idx_q)*LANES*7 +: LANES*7] : '0;
  assign tx_idx     = idx_q;
  assign tx_last    = tx_valid && (idx_q == IDXW'(BEATS - 1));
  assign busy       = (state_q == SEND);
  assign frame_done = done_q;
  assign load_ready = rdy_q;

endmodule

// File: tb/tb_hamming_tx_encoder.sv
// Directed bench for hamming_tx_encoder at WIDTH=128, LANES=4 (8 beats of
// 4 codewords). Expected beats are hand-computed codeword constants.
module tb_hamming_tx_encoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [127:0] load_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [27:0]  tx_data;
  logic [2:0]   tx_idx;
  logic         tx_last;
  logic         busy;
  logic         frame_done;
`ifdef HAM_TX_ERR_INJECT_EN
  logic         inj_arm;
  logic [4:0]   inj_block;
  logic [2:0]   inj_bit;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [27:0] exp_beat [8];

  // nibble k in block 4k (lane 0 of beat k), everything else zero
  localparam logic [127:0] RAMP = 128'h0007_0006_0005_0004_0003_0002_0001_0000;

  hamming_tx_encoder #(.WIDTH(128), .LANES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_idx     (tx_idx),
    .tx_last    (tx_last),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef HAM_TX_ERR_INJECT_EN
    ,
    .inj_arm    (inj_arm),
    .inj_block  (inj_block),
    .inj_bit    (inj_bit)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_zero_beats();
    for (int k = 0; k < 8; k++) exp_beat[k] = 28'h0;
  endtask

  task automatic set_ramp_beats();
    exp_beat[0] = 28'h00;
    exp_beat[1] = 28'h71;
    exp_beat[2] = 28'h32;
    exp_beat[3] = 28'h43;
    exp_beat[4] = 28'h54;
    exp_beat[5] = 28'h25;
    exp_beat[6] = 28'h66;
    exp_beat[7] = 28'h17;
  endtask

  task automatic load_word(input logic [127:0] w);
    int guard = 0;
    load_data  = w;
    load_valid = 1'b1;
    while (!load_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("load_ready_wait", 64'(load_ready), 64'(1));
    tick();
    load_valid = 1'b0;
  endtask

  // Walk one frame; optional stall on one beat and an intruding load that
  // stays asserted from intr_beat to the end of the frame.
  task automatic recv_frame(input int stall_beat, input int stall_n, input int intr_beat);
    int cyc = 0;
    for (int k = 0; k < 8; k++) begin
      check("tx_valid", 64'(tx_valid), 64'(1));
      check("tx_idx", 64'(tx_idx), 64'(k));
      check("tx_data", 64'(tx_data), 64'(exp_beat[k]));
      check("tx_last", 64'(tx_last), 64'(k == 7));
      check("busy", 64'(busy), 64'(1));
      check("load_ready_send", 64'(load_ready), 64'(0));
      if (k == intr_beat) begin
        load_valid = 1'b1;
        load_data  = '1;
      end
      if (k == stall_beat) begin
        tx_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          cyc++;
          check("hold_valid", 64'(tx_valid), 64'(1));
          check("hold_idx", 64'(tx_idx), 64'(k));
          check("hold_data", 64'(tx_data), 64'(exp_beat[k]));
        end
        tx_ready = 1'b1;
      end
      tick();
      cyc++;
    end
    check("frame_cycles", 64'(cyc), 64'(8 + stall_n));
    check("frame_done", 64'(frame_done), 64'(1));
    check("idle_valid", 64'(tx_valid), 64'(0));
    check("idle_data", 64'(tx_data), 64'(0));
    check("idle_idx", 64'(tx_idx), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_ready", 64'(load_ready), 64'(1));
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    tx_ready   = 1'b1;
`ifdef HAM_TX_ERR_INJECT_EN
    inj_arm    = 1'b0;
    inj_block  = '0;
    inj_bit    = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_load_ready", 64'(load_ready), 64'(0));
    check("rst_tx_valid", 64'(tx_valid), 64'(0));
    check("rst_tx_data", 64'(tx_data), 64'(0));
    check("rst_tx_idx", 64'(tx_idx), 64'(0));
    check("rst_tx_last", 64'(tx_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    rst = 1'b0;
    tick();
    check("post_rst_ready", 64'(load_ready), 64'(1));

    // all-zero word
    set_zero_beats();
    load_word(128'h0);
    recv_frame(-1, 0, -1);
    tick();
    check("frame_done_pulse", 64'(frame_done), 64'(0));

    // nibbles 1,F,0,A in beat 0
    set_zero_beats();
    exp_beat[0] = 28'hB403FF1;
    load_word(128'hA0F1);
    recv_frame(-1, 0, -1);

    // distinct codeword per beat, 3-cycle stall on beat 2
    set_ramp_beats();
    load_word(RAMP);
    recv_frame(2, 3, -1);

    // load attempt during SEND is ignored; it lands after frame_done
    set_zero_beats();
    exp_beat[0] = 28'hB403FF1;
    load_word(128'hA0F1);
    recv_frame(-1, 0, 3);
    for (int k = 0; k < 8; k++) exp_beat[k] = 28'hFFFFFFF;
    load_word('1);
    recv_frame(-1, 0, -1);

    // reset on beat 4 aborts the frame
    set_ramp_beats();
    load_word(RAMP);
    repeat (4) tick();
    check("pre_rst_idx", 64'(tx_idx), 64'(4));
    rst = 1'b1;
    #1;
    check("abort_valid", 64'(tx_valid), 64'(0));
    check("abort_data", 64'(tx_data), 64'(0));
    check("abort_idx", 64'(tx_idx), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_ready", 64'(load_ready), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    check("abort_post_ready", 64'(load_ready), 64'(1));
    check("abort_post_valid", 64'(tx_valid), 64'(0));
    load_word(RAMP);
    recv_frame(-1, 0, -1);

`ifdef HAM_TX_ERR_INJECT_EN
    // flip bit 6 of block 5 (beat 1, lane 1)
    set_zero_beats();
    exp_beat[1] = 28'h0002000;
    inj_arm   = 1'b1;
    inj_block = 5'd5;
    inj_bit   = 3'd6;
    load_word(128'h0);
    inj_arm   = 1'b0;
    recv_frame(-1, 0, -1);
    set_zero_beats();
    load_word(128'h0);
    recv_frame(-1, 0, -1);
    // bit index 7 means no injection
    inj_arm   = 1'b1;
    inj_bit   = 3'd7;
    load_word(128'h0);
    inj_arm   = 1'b0;
    recv_frame(-1, 0, -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
